uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8: ce ticks per serial bit; even and >= 4.
REQ-002 SHALL have parameter SIZE, default 7: index of the data MSB, so a frame carries SIZE+1 data bits.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ce, input, 1 bit: baud-tick enable; counters and the FSM advance only on cycles with ce=1.
REQ-006 SHALL have port i_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port o_data_byte, output, SIZE+1 bits: last correctly received word.
REQ-008 SHALL have port o_data_valid, output, 1 bit: one-clk pulse when a good frame completes.
REQ-009 SHALL have port o_frame_err, output, 1 bit: one-clk pulse when the stop bit samples low.
REQ-010 SHALL have port o_active, output, 1 bit: high in every state except IDLE.

Function
REQ-011 SHALL pass i_rx through a two-flop synchronizer clocked every clk; the synchronized signal is rx_s, and all sampling uses rx_s.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, CLEANUP.
REQ-013 IDLE: on a ce tick with rx_s=0 -> START, tick counter=0.
REQ-014 START: on each ce tick, if counter=CLKS_PER_BIT/2-1, then go to DATA (counter=0, bit index=0) if rx_s=0, else go to IDLE (glitch reject); otherwise increment counter.
REQ-015 DATA: on each ce tick, if counter=CLKS_PER_BIT-1, then shift rx_s into the shift register LSB-first and reset counter to 0; go to STOP if the bit index is SIZE, else increment the index; otherwise increment counter.
REQ-016 STOP: on the ce tick with counter=CLKS_PER_BIT-1, go to CLEANUP:
- if rx_s=1: load o_data_byte from the shift register and pulse o_data_valid;
- otherwise: pulse o_frame_err.
REQ-017 CLEANUP: on a ce tick with rx_s=1 -> IDLE; otherwise stay (break condition, no re-arm while the line is low).
REQ-018 o_data_valid and o_frame_err SHALL each be high for exactly one clk, never simultaneously, regardless of ce spacing.
REQ-019 o_data_byte SHALL change only when o_data_valid pulses; it holds through frame errors and glitches.
REQ-020 Latency: the valid/err pulse SHALL appear in the clk after the (CLKS_PER_BIT/2 + (SIZE+2)*CLKS_PER_BIT)-th ce tick following the IDLE detect tick (76 ticks at the defaults).
REQ-021 ce=0 SHALL freeze the FSM, counters and shift register; it SHALL NOT freeze the synchronizer.
REQ-022 A new frame SHALL be accepted on the first ce tick in IDLE, so back-to-back frames with a single stop bit are received without loss.

Reset
REQ-023 reset=0 SHALL asynchronously force:
- state=IDLE;
- counters, bit index and shift register to 0;
- o_data_byte=0, o_data_valid=0, o_frame_err=0, o_active=0;
- synchronizer flops to 1.
REQ-024 Reset mid-frame SHALL abort the frame with no valid or err pulse; reception resumes at the first falling edge after release.

Structure
REQ-025 The state enum SHALL live in shared package uart_pkg, which uart_tx also uses.
REQ-026 The synchronizer SHALL be sub-module sync_2ff (1 bit, reset value 1).
REQ-027 The ce source SHALL be an external clock_enable instance; the block contains no baud divider.

Verification (CLKS_PER_BIT=8, SIZE=7, ce=1 every clk unless stated)
REQ-028 Send 0xA5 with a high stop bit -> o_data_byte=0xA5, one o_data_valid pulse 76 ticks after detect, o_frame_err=0.
REQ-029 Drive i_rx low for 2 ticks, then high -> FSM returns to IDLE, no pulses, o_data_byte unchanged.
REQ-030 Send 0x3C with a low stop bit, hold the line low for 20 bits, then release -> one o_frame_err pulse, o_data_byte keeps its prior value, and o_active stays high until release.
REQ-031 Send 0x00 then 0xFF back-to-back -> two valid pulses exactly 80 ticks apart with correct bytes.
REQ-032 Assert reset during data bit 4 -> outputs zero at once, no pulse; the next frame 0x5A is received correctly.
REQ-033 Set ce high every 4th clk and send 0x81 -> byte correct, with latency 76 ticks (about 304 clk).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_pkg;

  // Receiver/transmitter FSM states; uart_tx uses the same encoding
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_t;

  // Number of ce ticks from the start-bit edge to the middle of the start bit
  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: baud enable and serial line in, received word and status pulses out.
// Latency: n/a (wiring only).
// Backpressure: none; o_data_valid/o_frame_err are single-clk pulses the consumer must catch.
interface uart_rx_if #(
  parameter int SIZE = 7
) ();
  logic            ce;
  logic            i_rx;
  logic [SIZE:0]   o_data_byte;
  logic            o_data_valid;
  logic            o_frame_err;
  logic            o_active;

  // Receiver side
  modport slave (
    input  ce,
    input  i_rx,
    output o_data_byte,
    output o_data_valid,
    output o_frame_err,
    output o_active
  );

  // Driver/consumer side
  modport master (
    output ce,
    output i_rx,
    input  o_data_byte,
    input  o_data_valid,
    input  o_frame_err,
    input  o_active
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, clocked every clk.
// Latency: 2 clk from i_d to o_q.
// Backpressure: none; free-running and never gated by ce.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  // Two back-to-back flops; reset to the idle level of the line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit detect, mid-bit sampling, LSB-first data, stop check.
// Latency: pulse in the clk after the (CLKS_PER_BIT/2 + (SIZE+2)*CLKS_PER_BIT)-th ce tick after detect.
// Backpressure: none; ce=0 freezes FSM/counters/shift register, outputs are one-clk pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SIZE         = 7
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam int            IW        = (SIZE > 0) ? $clog2(SIZE + 1) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(half_bit(CLKS_PER_BIT) - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(SIZE);

  uart_state_t   r_state;
  uart_state_t   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [SIZE:0] r_shift;
  logic [SIZE:0] r_data_byte;
  logic          r_data_valid;
  logic          r_frame_err;

  logic          w_rx_s;
  logic          w_half_done;
  logic          w_bit_done;
  logic          w_shift_en;
  logic          w_stop_good;
  logic          w_stop_bad;
  logic          w_active;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.i_rx),
    .o_q   (w_rx_s)
  );

  assign w_half_done = (r_cnt == HALF_LAST);
  assign w_bit_done  = (r_cnt == BIT_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; nothing moves without a ce tick
  always_comb begin
    w_state_nxt = r_state;
    if (bus.ce) begin
      unique case (r_state)
        IDLE:    if (!w_rx_s) w_state_nxt = START;
        START:   if (w_half_done) w_state_nxt = w_rx_s ? IDLE : DATA;
        DATA:    if (w_bit_done && (r_idx == IDX_LAST)) w_state_nxt = STOP;
        STOP:    if (w_bit_done) w_state_nxt = CLEANUP;
        CLEANUP: if (w_rx_s) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Output/strobe decode from the current state and the tick counter
  always_comb begin
    w_active    = (r_state != IDLE);
    w_shift_en  = bus.ce && (r_state == DATA) && w_bit_done;
    w_stop_good = bus.ce && (r_state == STOP) && w_bit_done && w_rx_s;
    w_stop_bad  = bus.ce && (r_state == STOP) && w_bit_done && !w_rx_s;
  end

  // Tick counter: half a bit in START, a full bit in DATA/STOP, parked at 0 elsewhere
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (bus.ce) begin
      unique case (r_state)
        START:      r_cnt <= w_half_done ? '0 : r_cnt + 1'b1;
        DATA, STOP: r_cnt <= w_bit_done ? '0 : r_cnt + 1'b1;
        default:    r_cnt <= '0;
      endcase
    end
  end

  // Bit index: cleared while hunting the start bit, advanced on each data sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx <= '0;
    end else if (bus.ce) begin
      if (r_state == START) begin
        r_idx <= '0;
      end else if (w_shift_en && (r_idx != IDX_LAST)) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Shift register fills from the top so the first (LSB) bit lands in bit 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
    end else if (w_shift_en) begin
      r_shift <= {w_rx_s, r_shift[SIZE:1]};
    end
  end

  // Result registers: pulses last one clk; the word only updates on a good stop bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_byte  <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= w_stop_good;
      r_frame_err  <= w_stop_bad;
      if (w_stop_good) begin
        r_data_byte <= r_shift;
      end
    end
  end

  assign bus.o_data_byte  = r_data_byte;
  assign bus.o_data_valid = r_data_valid;
  assign bus.o_frame_err  = r_frame_err;
  assign bus.o_active     = w_active;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level sample-point model compared every clk,
// plus hand-computed literal checks for bytes, pulse counts and latencies.
module tb_uart_rx;
  localparam int CPB    = 8;
  localparam int SIZE   = 7;
  localparam int HALF   = CPB / 2;
  localparam int STOP_T = HALF + (SIZE + 2) * CPB;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_rx_if #(.SIZE(SIZE)) bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ce generator: high on every ce_div-th clk edge
  int ce_div = 1;
  int ce_ph  = 0;
  initial begin
    bus.ce = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ce_ph  = (ce_ph + 1) % ce_div;
      bus.ce = (ce_ph == 0);
    end
  end

  // Frame-level model: rx_s is i_rx two clks late; sample points are fixed tick offsets from detect
  int         m_mode   = 0;   // 0 idle, 1 in frame, 2 waiting for the line to go high
  int         m_t      = 0;
  logic [7:0] m_sh     = '0;
  logic [7:0] m_byte   = '0;
  logic       m_valid  = 1'b0;
  logic       m_err    = 1'b0;
  logic       m_active = 1'b0;
  logic       m_h1     = 1'b1;
  logic       m_h2     = 1'b1;
  logic       m_rxs;
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_mode = 0; m_t = 0; m_sh = '0; m_byte = '0;
      m_valid = 1'b0; m_err = 1'b0; m_h1 = 1'b1; m_h2 = 1'b1;
    end else begin
      m_rxs   = m_h2;
      m_h2    = m_h1;
      m_h1    = bus.i_rx;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (bus.ce) begin
        case (m_mode)
          0: if (!m_rxs) begin m_mode = 1; m_t = 0; end
          1: begin
            m_t++;
            if (m_t == HALF && m_rxs) m_mode = 0;
            else if (m_t > HALF && m_t < STOP_T && ((m_t - HALF) % CPB) == 0)
              m_sh = {m_rxs, m_sh[7:1]};
            else if (m_t == STOP_T) begin
              if (m_rxs) begin m_byte = m_sh; m_valid = 1'b1; end
              else m_err = 1'b1;
              m_mode = 2;
            end
          end
          default: if (m_rxs) m_mode = 0;
        endcase
      end
    end
    m_active = (m_mode != 0);
  end

  // Compare process and pulse monitor, sampled mid-cycle
  int         n_valid = 0;
  int         n_err   = 0;
  int         valid_cyc[$];
  logic [7:0] valid_byte[$];
  initial forever begin
    @(negedge clk);
    if (bus.o_data_valid === 1'b1) begin
      n_valid++;
      valid_cyc.push_back(cyc);
      valid_byte.push_back(bus.o_data_byte);
    end
    if (bus.o_frame_err === 1'b1) n_err++;
    chk("model_data_valid", 32'(bus.o_data_valid), 32'(m_valid));
    chk("model_frame_err",  32'(bus.o_frame_err),  32'(m_err));
    chk("model_active",     32'(bus.o_active),     32'(m_active));
    chk("model_data_byte",  32'(bus.o_data_byte),  32'(m_byte));
  end

  task automatic tick_wait(input int n);
    repeat (n) begin
      do @(posedge clk); while (bus.ce !== 1'b1);
    end
    #1;
  endtask

  task automatic send_bits(input logic [7:0] d, input logic stp, input int nbits);
    logic [9:0] fr;
    fr = {stp, d, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      bus.i_rx = fr[0];
      fr       = fr >> 1;
      tick_wait(CPB);
    end
  endtask

  task automatic wait_valid(input int n_before, input int max_clks, input string name);
    int k;
    k = 0;
    while (n_valid == n_before && k < max_clks) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(name, 32'(n_valid > n_before), 32'd1);
  endtask

  int nv;
  int ne;
  int t0;

  initial begin
    bus.i_rx = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_data_byte",  32'(bus.o_data_byte),  32'h0);
    chk("reset_data_valid", 32'(bus.o_data_valid), 32'h0);
    chk("reset_frame_err",  32'(bus.o_frame_err),  32'h0);
    chk("reset_active",     32'(bus.o_active),     32'h0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (10) @(posedge clk);

    // 0xA5, good stop bit
    tick_wait(1);
    t0 = cyc; nv = n_valid;
    send_bits(8'hA5, 1'b1, 10);
    bus.i_rx = 1'b1;
    wait_valid(nv, 50, "a5_valid_seen");
    repeat (10) @(posedge clk); #1;
    chk("a5_byte",    32'(valid_byte[$]), 32'hA5);
    chk("a5_latency", 32'(valid_cyc[$] - t0), 32'd79);
    chk("a5_count",   32'(n_valid), 32'd1);
    chk("a5_no_err",  32'(n_err), 32'd0);

    // Short low glitch: detected, then rejected at the start-bit midpoint
    tick_wait(1);
    bus.i_rx = 1'b0;
    tick_wait(2);
    bus.i_rx = 1'b1;
    @(posedge clk); #1;
    chk("glitch_active_seen", 32'(bus.o_active), 32'd1);
    repeat (20) @(posedge clk); #1;
    chk("glitch_idle",     32'(bus.o_active), 32'd0);
    chk("glitch_no_valid", 32'(n_valid), 32'd1);
    chk("glitch_no_err",   32'(n_err), 32'd0);
    chk("glitch_byte",     32'(bus.o_data_byte), 32'hA5);

    // 0x3C with low stop bit, then a 20-bit break
    tick_wait(1);
    send_bits(8'h3C, 1'b0, 10);
    tick_wait(20 * CPB);
    chk("break_active_held", 32'(bus.o_active), 32'd1);
    chk("break_err_count",   32'(n_err), 32'd1);
    chk("break_no_valid",    32'(n_valid), 32'd1);
    chk("break_byte_kept",   32'(bus.o_data_byte), 32'hA5);
    bus.i_rx = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("break_released", 32'(bus.o_active), 32'd0);
    chk("break_err_once", 32'(n_err), 32'd1);

    // Back-to-back 0x00, 0xFF with a single stop bit
    tick_wait(1);
    nv = n_valid;
    send_bits(8'h00, 1'b1, 10);
    send_bits(8'hFF, 1'b1, 10);
    bus.i_rx = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk("b2b_count", 32'(n_valid), 32'(nv + 2));
    chk("b2b_byte0", 32'(valid_byte[nv]), 32'h00);
    chk("b2b_byte1", 32'(valid_byte[nv + 1]), 32'hFF);
    chk("b2b_gap",   32'(valid_cyc[nv + 1] - valid_cyc[nv]), 32'd80);

    // Reset in the middle of data bit 4 of 0xC3 (bit 4 is 0)
    tick_wait(1);
    nv = n_valid; ne = n_err;
    send_bits(8'hC3, 1'b1, 5);
    bus.i_rx = 1'b0;
    tick_wait(4);
    reset = 1'b0;
    #1;
    chk("rst_byte_zero",   32'(bus.o_data_byte), 32'h0);
    chk("rst_active_zero", 32'(bus.o_active), 32'h0);
    chk("rst_valid_zero",  32'(bus.o_data_valid), 32'h0);
    bus.i_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(posedge clk);
    tick_wait(1);
    send_bits(8'h5A, 1'b1, 10);
    bus.i_rx = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk("rst_next_count", 32'(n_valid), 32'(nv + 1));
    chk("rst_no_err",     32'(n_err), 32'(ne));
    chk("rst_next_byte",  32'(valid_byte[$]), 32'h5A);

    // ce on every 4th clk, 0x81
    ce_div = 4;
    repeat (8) @(posedge clk);
    tick_wait(1);
    t0 = cyc; nv = n_valid;
    send_bits(8'h81, 1'b1, 10);
    bus.i_rx = 1'b1;
    wait_valid(nv, 400, "ce4_valid_seen");
    repeat (10) @(posedge clk); #1;
    chk("ce4_byte",    32'(valid_byte[$]), 32'h81);
    chk("ce4_latency", 32'(valid_cyc[$] - t0), 32'd308);
    chk("ce4_no_err",  32'(n_err), 32'(ne));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, want completion", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
